// File: rtl/i2s_master_if.sv
// Valid/ready stream bundle carrying one packed stereo sample per beat.
// The master drives data/valid and the slave drives ready.
interface axis_if #(
    parameter int W = 48
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/i2s_master.sv
// I2S clock master: divides clk into bclk/lrclk, serializes DAC samples and
// deserializes ADC samples. Define I2S_MASTER_STATUS_EN for sticky over/underrun flags.
module i2s_master #(
    parameter int HALF_BCLK_CYCLES = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   enabled,
    axis_if.slave  dac_sample,
    axis_if.master adc_sample,
    input  logic   sdata_i,
    output logic   sdata_o,
    output logic   bclk,
    output logic   lrclk
`ifdef I2S_MASTER_STATUS_EN
    ,
    output logic [1:0] status_o,
    input  logic       status_clr
`endif
);
    localparam int DW = (HALF_BCLK_CYCLES > 2) ? $clog2(HALF_BCLK_CYCLES) : 1;

    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [5:0]    next_bit;
    logic [47:0]   hold;
    logic          hold_full;
    logic [47:0]   tx_sh;
    logic [46:0]   rx_sh;
    logic [47:0]   rx_next;
    logic          wrap, fall, rise;
    logic          frame_load, word_done, dac_hs;
    logic          underrun_ev, overrun_ev;

    // Frame slots that carry payload: left bits 1..24, right bits 33..56.
    function automatic logic data_slot(input logic [5:0] n);
        return (n >= 6'd1 && n <= 6'd24) || (n >= 6'd33 && n <= 6'd56);
    endfunction

    assign wrap       = (div_cnt == DW'(HALF_BCLK_CYCLES - 1));
    assign fall       = enabled & wrap & bclk;
    assign rise       = enabled & wrap & ~bclk;
    assign next_bit   = bit_cnt + 6'd1;
    assign frame_load = fall & (next_bit == 6'd0);
    assign word_done  = rise & (bit_cnt == 6'd56);
    assign rx_next    = {rx_sh, sdata_i};

    assign dac_sample.ready = reset & enabled & ~hold_full;
    assign dac_hs           = dac_sample.valid & dac_sample.ready;
    assign underrun_ev      = frame_load & ~hold_full;
    assign overrun_ev       = word_done & adc_sample.valid & ~adc_sample.ready;

    // Reset parks bit_cnt at 63 so the restart after reset matches the
    // restart after enable: the first fall opens frame bit 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt          <= '0;
            bit_cnt          <= 6'd63;
            bclk             <= 1'b0;
            lrclk            <= 1'b0;
            sdata_o          <= 1'b0;
            hold             <= '0;
            hold_full        <= 1'b0;
            tx_sh            <= '0;
            rx_sh            <= '0;
            adc_sample.data  <= '0;
            adc_sample.valid <= 1'b0;
        end else begin
            // Frame load takes the old hold; a same-cycle handshake refills it.
            if (dac_hs) begin
                hold      <= dac_sample.data;
                hold_full <= 1'b1;
            end else if (frame_load) begin
                hold_full <= 1'b0;
            end

            if (word_done) begin
                adc_sample.data  <= rx_next;
                adc_sample.valid <= 1'b1;
            end else if (adc_sample.ready) begin
                adc_sample.valid <= 1'b0;
            end

            if (!enabled) begin
                div_cnt <= '0;
                bit_cnt <= 6'd63;
                bclk    <= 1'b0;
                lrclk   <= 1'b0;
                sdata_o <= 1'b0;
                rx_sh   <= '0;
            end else begin
                div_cnt <= wrap ? '0 : div_cnt + DW'(1);
                if (wrap)
                    bclk <= ~bclk;

                if (fall) begin
                    bit_cnt <= next_bit;
                    lrclk   <= next_bit[5];
                    if (next_bit == 6'd0) begin
                        tx_sh   <= hold_full ? hold : 48'h0;
                        sdata_o <= 1'b0;
                    end else if (data_slot(next_bit)) begin
                        sdata_o <= tx_sh[47];
                        tx_sh   <= {tx_sh[46:0], 1'b0};
                    end else begin
                        sdata_o <= 1'b0;
                    end
                end

                if (rise && data_slot(bit_cnt))
                    rx_sh <= rx_next[46:0];
            end
        end
    end

`ifdef I2S_MASTER_STATUS_EN
    logic overrun_q, underrun_q;

    // Sticky flags; a set event beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= overrun_ev  | (overrun_q  & ~status_clr);
            underrun_q <= underrun_ev | (underrun_q & ~status_clr);
        end
    end

    assign status_o = {overrun_q, underrun_q};
`else
    logic unused_status;
    assign unused_status = overrun_ev ^ underrun_ev;
`endif

endmodule
